// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache burst reads and dcache reads/writes onto one memory port.
// Define CACHE_ARB_ICACHE_PRIO_EN to give icache fixed priority instead of round-robin.
module cache_mem_arbiter #(
   parameter int DATABITS  = 32,
   parameter int ADDRBITS  = 32,
   parameter int BURSTBITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [ADDRBITS-1:0]  ic_addr,
   input  logic                 ic_rdreq,
   output logic [DATABITS-1:0]  ic_out,
   output logic                 ic_out_valid,
   output logic                 ic_done,
   input  logic [ADDRBITS-1:0]  dc_addr,
   input  logic [DATABITS-1:0]  dc_in,
   input  logic                 dc_rdreq,
   input  logic                 dc_wrreq,
   output logic [DATABITS-1:0]  dc_out,
   output logic                 dc_out_valid,
   output logic                 dc_done,
   output logic [ADDRBITS-1:0]  mem_addr,
   output logic [DATABITS-1:0]  mem_in,
   output logic                 mem_rdreq,
   output logic                 mem_wrreq,
   input  logic [DATABITS-1:0]  mem_out,
   input  logic                 mem_out_valid,
   input  logic                 mem_ready,
   input  logic [BURSTBITS-1:0] mem_burstlen,
   output logic                 arb_busy
);

   typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, DC_WR} state_t;

   state_t               state;
   logic [BURSTBITS-1:0] burst_cnt;
   logic                 ic_req;
   logic                 dc_req;
   logic                 grant_ic;

   assign ic_req = ic_rdreq;
   assign dc_req = dc_rdreq | dc_wrreq;

`ifdef CACHE_ARB_ICACHE_PRIO_EN
   assign grant_ic = ic_req;
`else
   // last_dc=1 means dcache held the bus last, so icache wins the next tie
   logic last_dc;
   assign grant_ic = ic_req & (~dc_req | last_dc);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last_dc <= 1'b1;
      else if (state == IDLE && mem_ready && (ic_req || dc_req))
         last_dc <= ~grant_ic;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         burst_cnt <= '0;
         mem_addr  <= '0;
         mem_in    <= '0;
         mem_rdreq <= 1'b0;
         mem_wrreq <= 1'b0;
         ic_done   <= 1'b0;
         dc_done   <= 1'b0;
      end else begin
         mem_rdreq <= 1'b0;
         mem_wrreq <= 1'b0;
         ic_done   <= 1'b0;
         dc_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_ready && (ic_req || dc_req)) begin
                  burst_cnt <= (mem_burstlen == '0) ? BURSTBITS'(1) : mem_burstlen;
                  if (grant_ic) begin
                     state     <= IC_RD;
                     mem_addr  <= ic_addr;
                     mem_rdreq <= 1'b1;
                  end else begin
                     mem_addr <= dc_addr;
                     if (dc_wrreq) begin
                        state     <= DC_WR;
                        mem_in    <= dc_in;
                        mem_wrreq <= 1'b1;
                     end else begin
                        state     <= DC_RD;
                        mem_rdreq <= 1'b1;
                     end
                  end
               end
            end
            IC_RD, DC_RD: begin
               if (mem_out_valid) begin
                  burst_cnt <= burst_cnt - BURSTBITS'(1);
                  if (burst_cnt == BURSTBITS'(1)) begin
                     state <= IDLE;
                     if (state == IC_RD)
                        ic_done <= 1'b1;
                     else
                        dc_done <= 1'b1;
                  end
               end
            end
            DC_WR: begin
               // mem_wrreq is high only in the command cycle, so it masks that cycle's ready
               if (!mem_wrreq && mem_ready) begin
                  state   <= IDLE;
                  dc_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arb_busy     = (state != IDLE);
   assign ic_out_valid = (state == IC_RD) & mem_out_valid;
   assign dc_out_valid = (state == DC_RD) & mem_out_valid;
   assign ic_out       = (state == IC_RD) ? mem_out : '0;
   assign dc_out       = (state == DC_RD) ? mem_out : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: the bench plays the memory, a monitor
// scoreboards routed words and done pulses against expected queues.
module tb_cache_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] ic_addr;
   logic          ic_rdreq;
   logic [DW-1:0] ic_out;
   logic          ic_out_valid;
   logic          ic_done;
   logic [AW-1:0] dc_addr;
   logic [DW-1:0] dc_in;
   logic          dc_rdreq;
   logic          dc_wrreq;
   logic [DW-1:0] dc_out;
   logic          dc_out_valid;
   logic          dc_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_in;
   logic          mem_rdreq;
   logic          mem_wrreq;
   logic [DW-1:0] mem_out;
   logic          mem_out_valid;
   logic          mem_ready;
   logic [BW-1:0] mem_burstlen;
   logic          arb_busy;

   cache_mem_arbiter #(.DATABITS(DW), .ADDRBITS(AW), .BURSTBITS(BW)) dut (
      .clk(clk), .reset_n(reset_n),
      .ic_addr(ic_addr), .ic_rdreq(ic_rdreq), .ic_out(ic_out),
      .ic_out_valid(ic_out_valid), .ic_done(ic_done),
      .dc_addr(dc_addr), .dc_in(dc_in), .dc_rdreq(dc_rdreq), .dc_wrreq(dc_wrreq),
      .dc_out(dc_out), .dc_out_valid(dc_out_valid), .dc_done(dc_done),
      .mem_addr(mem_addr), .mem_in(mem_in), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
      .mem_out(mem_out), .mem_out_valid(mem_out_valid), .mem_ready(mem_ready),
      .mem_burstlen(mem_burstlen), .arb_busy(arb_busy)
   );

   // clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] ic_exp_q[$];
   logic [DW-1:0] dc_exp_q[$];
   logic          done_exp_q[$];   // 0 = icache done, 1 = dcache done

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (ic_out_valid) begin
         check("ic_word_expected", 32'(ic_exp_q.size() != 0), 32'd1);
         if (ic_exp_q.size() != 0) check("ic_out", ic_out, ic_exp_q.pop_front());
      end
      if (dc_out_valid) begin
         check("dc_word_expected", 32'(dc_exp_q.size() != 0), 32'd1);
         if (dc_exp_q.size() != 0) check("dc_out", dc_out, dc_exp_q.pop_front());
      end
      if (ic_done) begin
         check("ic_done_expected", 32'(done_exp_q.size() != 0), 32'd1);
         if (done_exp_q.size() != 0) check("ic_done_owner", 32'(done_exp_q.pop_front()), 32'd0);
      end
      if (dc_done) begin
         check("dc_done_expected", 32'(done_exp_q.size() != 0), 32'd1);
         if (done_exp_q.size() != 0) check("dc_done_owner", 32'(done_exp_q.pop_front()), 32'd1);
      end
   end

   // driver tasks
   task automatic wait_cmd();
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_rdreq || mem_wrreq) begin
            seen = 1'b1;
            break;
         end
      end
      check("cmd_seen", 32'(seen), 32'd1);
   endtask

   task automatic run_read(input bit is_ic, input logic [31:0] addr, input int n,
                           input logic [31:0] base, input int drop_at);
      wait_cmd();
      check("rd_cmd_rdreq", 32'(mem_rdreq), 32'd1);
      check("rd_cmd_wrreq", 32'(mem_wrreq), 32'd0);
      check("rd_cmd_addr", mem_addr, addr);
      check("rd_cmd_busy", 32'(arb_busy), 32'd1);
      mem_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mem_out_valid = 1'b1;
         mem_out       = base + 32'(i);
         if (is_ic) ic_exp_q.push_back(base + 32'(i));
         else       dc_exp_q.push_back(base + 32'(i));
         if (i == drop_at) begin
            ic_rdreq = 1'b0;
            dc_rdreq = 1'b0;
         end
         if (i == 0) begin
            @(negedge clk);
            check("rdreq_one_cycle", 32'(mem_rdreq), 32'd0);
         end
      end
      @(posedge clk); #1;
      mem_out_valid = 1'b0;
      mem_ready     = 1'b1;
      done_exp_q.push_back(!is_ic);
      @(negedge clk);
      check("rd_done", 32'(is_ic ? ic_done : dc_done), 32'd1);
      check("rd_end_busy", 32'(arb_busy), 32'd0);
   endtask

   task automatic run_write(input logic [31:0] addr, input logic [31:0] data);
      wait_cmd();
      check("wr_cmd_wrreq", 32'(mem_wrreq), 32'd1);
      check("wr_cmd_rdreq", 32'(mem_rdreq), 32'd0);
      check("wr_cmd_addr", mem_addr, addr);
      check("wr_cmd_data", mem_in, data);
      mem_ready = 1'b0;
      @(negedge clk);
      check("wrreq_one_cycle", 32'(mem_wrreq), 32'd0);
      check("wr_busy", 32'(arb_busy), 32'd1);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      dc_wrreq  = 1'b0;
      done_exp_q.push_back(1'b1);
      @(negedge clk);
      check("wr_done_not_early", 32'(dc_done), 32'd0);
      check("wr_busy_on_ready", 32'(arb_busy), 32'd1);
      @(negedge clk);
      check("wr_done", 32'(dc_done), 32'd1);
      check("wr_end_busy", 32'(arb_busy), 32'd0);
   endtask

   task automatic stray_words(input int n, input logic [31:0] base);
      mem_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mem_out_valid = 1'b1;
         mem_out       = base + 32'(i);
      end
      @(posedge clk); #1;
      mem_out_valid = 1'b0;
      mem_ready     = 1'b1;
      @(negedge clk);
      check("stray_idle_busy", 32'(arb_busy), 32'd0);
   endtask

   // clock/reset and directed stimulus
   initial begin
      reset_n       = 1'b0;
      ic_addr       = 32'h1000;
      ic_rdreq      = 1'b0;
      dc_addr       = 32'h2000;
      dc_in         = '0;
      dc_rdreq      = 1'b0;
      dc_wrreq      = 1'b0;
      mem_out       = 32'h5555_5555;
      mem_out_valid = 1'b1;
      mem_ready     = 1'b1;
      mem_burstlen  = 16'd8;
      repeat (2) @(negedge clk);
      check("rst_mem_rdreq", 32'(mem_rdreq), 32'd0);
      check("rst_mem_wrreq", 32'(mem_wrreq), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_in", mem_in, 32'd0);
      check("rst_busy", 32'(arb_busy), 32'd0);
      check("rst_ic_valid", 32'(ic_out_valid), 32'd0);
      check("rst_dc_valid", 32'(dc_out_valid), 32'd0);
      @(posedge clk); #1;
      mem_out_valid = 1'b0;
      reset_n       = 1'b1;

      // both caches request: icache first (flag resets to dcache), then the other
      ic_rdreq = 1'b1;
      dc_rdreq = 1'b1;
      run_read(1'b1, 32'h1000, 8, 32'hA000_0000, 99);
`ifdef CACHE_ARB_ICACHE_PRIO_EN
      run_read(1'b1, 32'h1000, 8, 32'hB000_0000, 0);
`else
      run_read(1'b0, 32'h2000, 8, 32'hB000_0000, 0);
`endif

      // write beats a simultaneous dcache read, then the read follows
      mem_burstlen = 16'd2;
      dc_addr      = 32'h100;
      dc_in        = 32'hDEAD_BEEF;
      dc_wrreq     = 1'b1;
      dc_rdreq     = 1'b1;
      run_write(32'h100, 32'hDEAD_BEEF);
      run_read(1'b0, 32'h100, 2, 32'hC000_0000, 0);

      // burst length 0 behaves as a single word; a following word is discarded
      mem_burstlen = 16'd0;
      ic_addr      = 32'h3000;
      ic_rdreq     = 1'b1;
      run_read(1'b1, 32'h3000, 1, 32'hD000_0000, 0);
      stray_words(2, 32'hDD00_0000);

      // request dropped after word 3 still completes the burst
      mem_burstlen = 16'd8;
      ic_addr      = 32'h4000;
      ic_rdreq     = 1'b1;
      run_read(1'b1, 32'h4000, 8, 32'hE000_0000, 3);

      // reset on word 4 abandons the burst
      ic_addr  = 32'h5000;
      ic_rdreq = 1'b1;
      wait_cmd();
      check("rst_burst_cmd", mem_addr, 32'h5000);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         mem_out_valid = 1'b1;
         mem_out       = 32'hF000_0000 + 32'(i);
         ic_exp_q.push_back(32'hF000_0000 + 32'(i));
      end
      @(negedge clk);
      #2;
      reset_n  = 1'b0;
      ic_rdreq = 1'b0;
      #1;
      check("midrst_ic_valid", 32'(ic_out_valid), 32'd0);
      check("midrst_busy", 32'(arb_busy), 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      check("midrst_ic_done", 32'(ic_done), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      stray_words(3, 32'hFF00_0000);

      repeat (3) @(negedge clk);
      check("ic_queue_drained", 32'(ic_exp_q.size()), 32'd0);
      check("dc_queue_drained", 32'(dc_exp_q.size()), 32'd0);
      check("done_queue_drained", 32'(done_exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
